// File: rtl/syn_global_pkg.sv
// Shared types and constants for the syn_* FPGA-top blocks.
// The bridge state enum and the default local-bus error word live here.
package syn_global_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } syn_mm_lb_bridge_st_t;

  localparam logic [31:0] P_LB_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/syn_lb_rd_mux.sv
// N:1 selector over the per-channel local-bus read-valid/read-data pairs.
// An out-of-range select yields valid=0 and data=0.
module syn_lb_rd_mux #(
  parameter int P_NUM_CH = 4,
  parameter int P_DWIDTH = 32,
  parameter int P_SEL_W  = 2
) (
  input  logic [P_SEL_W-1:0]           sel,
  input  logic [P_NUM_CH-1:0]          lb_rd_valid,
  input  logic [P_NUM_CH*P_DWIDTH-1:0] lb_rd_data,
  output logic                         rd_valid,
  output logic [P_DWIDTH-1:0]          rd_data
);

  always_comb begin
    rd_valid = 1'b0;
    rd_data  = '0;
    for (int i = 0; i < P_NUM_CH; i++) begin
      if (sel == P_SEL_W'(i)) begin
        rd_valid = lb_rd_valid[i];
        rd_data  = lb_rd_data[i*P_DWIDTH +: P_DWIDTH];
      end
    end
  end

endmodule

// File: rtl/syn_mm_lb_bridge.sv
// Avalon-MM slave fanned out to P_NUM_CH local-bus channels: one-cycle write
// strobes, a single outstanding read with timeout, and error statistics.
//
// state   | meaning
// IDLE    | accepting commands; writes issue here back-to-back
// RD_WAIT | read strobe issued, waiting for the selected channel's valid
// RESP    | mm_readdatavalid is high this cycle
module syn_mm_lb_bridge
  import syn_global_pkg::*;
#(
  parameter int P_NUM_CH    = 4,
  parameter int P_DWIDTH    = 32,
  parameter int P_CH_AWIDTH = 12,
  parameter int P_SEL_W     = (P_NUM_CH > 1) ? $clog2(P_NUM_CH) : 1,
  parameter int P_TIMEOUT   = 255,
  parameter logic [P_DWIDTH-1:0] P_ERR_DATA = P_DWIDTH'(P_LB_ERR_DATA)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [P_SEL_W+P_CH_AWIDTH+1:0]    mm_addr,
  input  logic                              mm_read,
  input  logic                              mm_write,
  input  logic [P_DWIDTH-1:0]               mm_writedata,
  output logic                              mm_waitrequest,
  output logic [P_DWIDTH-1:0]               mm_readdata,
  output logic                              mm_readdatavalid,
  output logic [P_CH_AWIDTH-1:0]            lb_addr,
  output logic [P_DWIDTH-1:0]               lb_wr_data,
  output logic [P_NUM_CH-1:0]               lb_wr_en,
  output logic [P_NUM_CH-1:0]               lb_rd_en,
  input  logic [P_NUM_CH-1:0]               lb_rd_valid,
  input  logic [P_NUM_CH*P_DWIDTH-1:0]      lb_rd_data,
  input  logic                              stat_clr,
  output logic [7:0]                        stat_timeout_cnt,
  output logic                              stat_err
);

  localparam int AW    = P_SEL_W + P_CH_AWIDTH + 2;
  localparam int SEL_N = 1 << P_SEL_W;
  localparam logic [15:0] TMO_LAST = 16'(P_TIMEOUT - 1);

  syn_mm_lb_bridge_st_t state_q, state_d;
  logic [P_SEL_W-1:0]     sel_q, sel_d;
  logic [15:0]            tmo_cnt_q, tmo_cnt_d;
  logic [P_CH_AWIDTH-1:0] lb_addr_q, lb_addr_d;
  logic [P_DWIDTH-1:0]    lb_wr_data_q, lb_wr_data_d;
  logic [P_NUM_CH-1:0]    lb_wr_en_q, lb_wr_en_d;
  logic [P_NUM_CH-1:0]    lb_rd_en_q, lb_rd_en_d;
  logic [P_DWIDTH-1:0]    rd_data_q, rd_data_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [7:0]             stat_cnt_q, stat_cnt_d, stat_cnt_base;
  logic                   stat_err_q, stat_err_d;

  logic [P_SEL_W-1:0]     cmd_sel;
  logic [P_CH_AWIDTH-1:0] cmd_word;
  logic [SEL_N-1:0]       ch_map, cmd_oh;
  logic                   cmd_mapped;
  logic                   mux_valid;
  logic [P_DWIDTH-1:0]    mux_data;
  logic                   err_evt, tmo_evt;
  logic                   addr_lsb_unused;

  assign cmd_sel         = mm_addr[AW-1:P_CH_AWIDTH+2];
  assign cmd_word        = mm_addr[P_CH_AWIDTH+1:2];
  assign addr_lsb_unused = ^mm_addr[1:0];
  assign cmd_oh          = SEL_N'(1) << cmd_sel;
  assign cmd_mapped      = ch_map[cmd_sel];

  // Select values at or beyond P_NUM_CH have no local-bus slave behind them.
  always_comb begin
    ch_map = '0;
    for (int i = 0; i < SEL_N; i++) ch_map[i] = (i < P_NUM_CH);
  end

  syn_lb_rd_mux #(
    .P_NUM_CH (P_NUM_CH),
    .P_DWIDTH (P_DWIDTH),
    .P_SEL_W  (P_SEL_W)
  ) u_rd_mux (
    .sel         (sel_q),
    .lb_rd_valid (lb_rd_valid),
    .lb_rd_data  (lb_rd_data),
    .rd_valid    (mux_valid),
    .rd_data     (mux_data)
  );

  assign mm_waitrequest = rst | (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    tmo_cnt_d    = tmo_cnt_q;
    lb_addr_d    = lb_addr_q;
    lb_wr_data_d = lb_wr_data_q;
    lb_wr_en_d   = '0;
    lb_rd_en_d   = '0;
    rd_data_d    = rd_data_q;
    err_evt      = 1'b0;
    tmo_evt      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A write wins over a simultaneous read; the read is dropped as an error.
        if (mm_write) begin
          lb_addr_d    = cmd_word;
          lb_wr_data_d = mm_writedata;
          if (cmd_mapped) lb_wr_en_d = cmd_oh[P_NUM_CH-1:0];
          else            err_evt    = 1'b1;
          if (mm_read) err_evt = 1'b1;
        end else if (mm_read) begin
          lb_addr_d = cmd_word;
          sel_d     = cmd_sel;
          tmo_cnt_d = '0;
          if (cmd_mapped) begin
            lb_rd_en_d = cmd_oh[P_NUM_CH-1:0];
            state_d    = RD_WAIT;
          end else begin
            rd_data_d = P_ERR_DATA;
            err_evt   = 1'b1;
            state_d   = RESP;
          end
        end
      end
      RD_WAIT: begin
        if (mux_valid) begin
          rd_data_d = mux_data;
          state_d   = RESP;
        end else if (tmo_cnt_q == TMO_LAST) begin
          rd_data_d = P_ERR_DATA;
          tmo_evt   = 1'b1;
          err_evt   = 1'b1;
          state_d   = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rd_valid_d = (state_d == RESP);

    // A clear in the same cycle as a new error still leaves the error recorded.
    stat_err_d    = err_evt ? 1'b1 : (stat_clr ? 1'b0 : stat_err_q);
    stat_cnt_base = stat_clr ? 8'd0 : stat_cnt_q;
    stat_cnt_d    = (tmo_evt && stat_cnt_base != 8'hFF) ? stat_cnt_base + 8'd1 : stat_cnt_base;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      tmo_cnt_q    <= '0;
      lb_addr_q    <= '0;
      lb_wr_data_q <= '0;
      lb_wr_en_q   <= '0;
      lb_rd_en_q   <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      stat_cnt_q   <= '0;
      stat_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      tmo_cnt_q    <= tmo_cnt_d;
      lb_addr_q    <= lb_addr_d;
      lb_wr_data_q <= lb_wr_data_d;
      lb_wr_en_q   <= lb_wr_en_d;
      lb_rd_en_q   <= lb_rd_en_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      stat_cnt_q   <= stat_cnt_d;
      stat_err_q   <= stat_err_d;
    end
  end

  assign mm_readdata      = rd_data_q;
  assign mm_readdatavalid = rd_valid_q;
  assign lb_addr          = lb_addr_q;
  assign lb_wr_data       = lb_wr_data_q;
  assign lb_wr_en         = lb_wr_en_q;
  assign lb_rd_en         = lb_rd_en_q;
  assign stat_timeout_cnt = stat_cnt_q;
  assign stat_err         = stat_err_q;

endmodule

// File: tb/tb_syn_mm_lb_bridge.sv
// Bench for syn_mm_lb_bridge: a 4-channel and a 3-channel instance, both with an
// 8-cycle read timeout, checked against a cycle-scheduled expectation model.
module tb_syn_mm_lb_bridge;

  localparam int TMO = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [15:0]  mm_addr_i  [2];
  logic         mm_read_i  [2];
  logic         mm_write_i [2];
  logic [31:0]  mm_wdata_i [2];
  logic [3:0]   rd_valid_i [2];
  logic [127:0] rd_data_i  [2];
  logic         stat_clr_i [2];

  wire        wait_o  [2];
  wire [31:0] rdata_o [2];
  wire        rdv_o   [2];
  wire [11:0] addr_o  [2];
  wire [31:0] wdata_o [2];
  wire [3:0]  wr_en_o [2];
  wire [3:0]  rd_en_o [2];
  wire [7:0]  cnt_o   [2];
  wire        err_o   [2];
  wire [2:0]  wr_en3, rd_en3;

  assign wr_en_o[1] = {1'b0, wr_en3};
  assign rd_en_o[1] = {1'b0, rd_en3};

  syn_mm_lb_bridge #(.P_NUM_CH(4), .P_TIMEOUT(TMO)) dut4 (
    .clk(clk), .rst(rst),
    .mm_addr(mm_addr_i[0]), .mm_read(mm_read_i[0]), .mm_write(mm_write_i[0]),
    .mm_writedata(mm_wdata_i[0]), .mm_waitrequest(wait_o[0]),
    .mm_readdata(rdata_o[0]), .mm_readdatavalid(rdv_o[0]),
    .lb_addr(addr_o[0]), .lb_wr_data(wdata_o[0]),
    .lb_wr_en(wr_en_o[0]), .lb_rd_en(rd_en_o[0]),
    .lb_rd_valid(rd_valid_i[0]), .lb_rd_data(rd_data_i[0]),
    .stat_clr(stat_clr_i[0]), .stat_timeout_cnt(cnt_o[0]), .stat_err(err_o[0])
  );

  syn_mm_lb_bridge #(.P_NUM_CH(3), .P_TIMEOUT(TMO)) dut3 (
    .clk(clk), .rst(rst),
    .mm_addr(mm_addr_i[1]), .mm_read(mm_read_i[1]), .mm_write(mm_write_i[1]),
    .mm_writedata(mm_wdata_i[1]), .mm_waitrequest(wait_o[1]),
    .mm_readdata(rdata_o[1]), .mm_readdatavalid(rdv_o[1]),
    .lb_addr(addr_o[1]), .lb_wr_data(wdata_o[1]),
    .lb_wr_en(wr_en3), .lb_rd_en(rd_en3),
    .lb_rd_valid(rd_valid_i[1][2:0]), .lb_rd_data(rd_data_i[1][95:0]),
    .stat_clr(stat_clr_i[1]), .stat_timeout_cnt(cnt_o[1]), .stat_err(err_o[1])
  );

  // Expected outputs keyed by (cycle, instance); absent key means strobe/valid low.
  logic [3:0]  exp_wr    [int];
  logic [3:0]  exp_rd    [int];
  logic [11:0] exp_addr  [int];
  logic [31:0] exp_wdata [int];
  logic [31:0] exp_rdv   [int];
  int          exp_cnt   [2];
  logic        exp_err   [2];
  int          last_rden [2];
  int          last_rdv  [2];
  logic [31:0] last_rdata[2];
  bit          chk_en = 1'b0;

  function automatic int key(input int c, input int i);
    return c * 2 + i;
  endfunction

  function automatic int nch(input int i);
    return (i == 0) ? 4 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    int k;
    logic [3:0] ew, er;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        k  = key(cyc, i);
        ew = exp_wr.exists(k) ? exp_wr[k] : 4'h0;
        er = exp_rd.exists(k) ? exp_rd[k] : 4'h0;
        chk($sformatf("lb_wr_en[%0d]", i), 32'(wr_en_o[i]), 32'(ew));
        chk($sformatf("lb_rd_en[%0d]", i), 32'(rd_en_o[i]), 32'(er));
        if (ew != 4'h0 || er != 4'h0) chk($sformatf("lb_addr[%0d]", i), 32'(addr_o[i]), 32'(exp_addr[k]));
        if (ew != 4'h0) chk($sformatf("lb_wr_data[%0d]", i), wdata_o[i], exp_wdata[k]);
        chk($sformatf("mm_readdatavalid[%0d]", i), 32'(rdv_o[i]), 32'(exp_rdv.exists(k)));
        if (exp_rdv.exists(k)) chk($sformatf("mm_readdata[%0d]", i), rdata_o[i], exp_rdv[k]);
        if (rd_en_o[i] != 4'h0) last_rden[i] = cyc;
        if (rdv_o[i] === 1'b1) begin
          last_rdv[i]   = cyc;
          last_rdata[i] = rdata_o[i];
        end
      end
    end
  end

  // Drive one command this cycle and record what it must cause one cycle later.
  task automatic cmd(input int i, input bit rd, input bit wr, input logic [15:0] a, input logic [31:0] d);
    int n, k;
    logic [1:0] s;
    bit mapped;
    n = cyc;
    s = a[15:14];
    mapped = (int'(s) < nch(i));
    k = key(n + 1, i);
    mm_addr_i[i] = a; mm_read_i[i] = rd; mm_write_i[i] = wr; mm_wdata_i[i] = d;
    if (wr) begin
      if (mapped) begin
        exp_wr[k] = 4'(1) << s; exp_addr[k] = a[13:2]; exp_wdata[k] = d;
      end else exp_err[i] = 1'b1;
      if (rd) exp_err[i] = 1'b1;
    end else if (rd) begin
      if (mapped) begin
        exp_rd[k] = 4'(1) << s; exp_addr[k] = a[13:2];
      end else begin
        exp_rdv[k] = ERR; exp_err[i] = 1'b1;
      end
    end
    tick();
  endtask

  // Read transaction; dly<0 means the slave never answers, vch is the channel that raises valid.
  task automatic rd_txn(input int i, input logic [15:0] a, input int dly, input int vch, input logic [31:0] vd);
    int n, r, vc, last;
    logic [1:0] s;
    logic [31:0] rexp;
    bit wr_hi;
    n  = cyc;
    s  = a[15:14];
    vc = (dly >= 0) ? n + 1 + dly : -1;
    if (int'(s) >= nch(i)) begin
      r = n + 1; rexp = ERR;
    end else if (dly >= 0 && vch == int'(s) && dly < TMO) begin
      r = n + 2 + dly; rexp = vd;
    end else begin
      r = n + 1 + TMO; rexp = ERR;
      exp_err[i] = 1'b1;
      if (exp_cnt[i] < 255) exp_cnt[i]++;
    end
    exp_rdv[key(r, i)] = rexp;
    cmd(i, 1'b1, 1'b0, a, 32'h0);
    mm_read_i[i] = 1'b0;
    last  = (vc > r) ? vc : r;
    wr_hi = 1'b1;
    while (cyc <= last) begin
      if (cyc == vc) begin
        rd_valid_i[i] = 4'(1) << vch;
        rd_data_i[i]  = {4{~vd}};
        rd_data_i[i][vch*32 +: 32] = vd;
      end else rd_valid_i[i] = 4'h0;
      if (cyc <= r) wr_hi = wr_hi & wait_o[i];
      tick();
    end
    rd_valid_i[i] = 4'h0;
    chk("waitrequest busy during read", 32'(wr_hi), 32'd1);
    chk("waitrequest low after resp", 32'(wait_o[i]), 32'd0);
    chk("stat_timeout_cnt", 32'(cnt_o[i]), exp_cnt[i]);
    chk("stat_err", 32'(err_o[i]), 32'(exp_err[i]));
  endtask

  task automatic clr(input int i);
    stat_clr_i[i] = 1'b1;
    exp_cnt[i] = 0; exp_err[i] = 1'b0;
    tick();
    stat_clr_i[i] = 1'b0;
    chk("clr stat_timeout_cnt", 32'(cnt_o[i]), 32'd0);
    chk("clr stat_err", 32'(err_o[i]), 32'd0);
  endtask

  task automatic chk_reset_vals(input int i);
    chk("rst waitrequest", 32'(wait_o[i]), 32'd1);
    chk("rst readdatavalid", 32'(rdv_o[i]), 32'd0);
    chk("rst readdata", rdata_o[i], 32'd0);
    chk("rst lb_addr", 32'(addr_o[i]), 32'd0);
    chk("rst lb_wr_data", wdata_o[i], 32'd0);
    chk("rst lb_wr_en", 32'(wr_en_o[i]), 32'd0);
    chk("rst lb_rd_en", 32'(rd_en_o[i]), 32'd0);
    chk("rst stat_timeout_cnt", 32'(cnt_o[i]), 32'd0);
    chk("rst stat_err", 32'(err_o[i]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      mm_addr_i[i] = '0; mm_read_i[i] = 1'b0; mm_write_i[i] = 1'b0; mm_wdata_i[i] = '0;
      rd_valid_i[i] = '0; rd_data_i[i] = '0; stat_clr_i[i] = 1'b0;
      exp_cnt[i] = 0; exp_err[i] = 1'b0; last_rden[i] = -1; last_rdv[i] = -1; last_rdata[i] = '0;
    end
    rst = 1'b1;
    tick(); tick();
    for (int i = 0; i < 2; i++) chk_reset_vals(i);
    rst = 1'b0;
    chk_en = 1'b1;
    tick();
    chk("idle waitrequest", 32'(wait_o[0]), 32'd0);

    // back-to-back writes
    cmd(0, 1'b0, 1'b1, 16'h0004, 32'hA5A5_0001);
    chk("b2b wr_en first", 32'(wr_en_o[0]), 32'h1);
    chk("b2b addr first", 32'(addr_o[0]), 32'd1);
    chk("b2b waitrequest", 32'(wait_o[0]), 32'd0);
    cmd(0, 1'b0, 1'b1, 16'h4008, 32'hA5A5_0002);
    chk("b2b wr_en second", 32'(wr_en_o[0]), 32'h2);
    chk("b2b addr second", 32'(addr_o[0]), 32'd2);
    chk("b2b waitrequest 2", 32'(wait_o[0]), 32'd0);
    mm_write_i[0] = 1'b0;
    tick();

    // read with 3-cycle slave delay
    rd_txn(0, 16'hC010, 3, 3, 32'h1234_5678);
    chk("rd delay latency", last_rdv[0] - last_rden[0], 32'd4);
    chk("rd delay data", last_rdata[0], 32'h1234_5678);

    // timeout, then a late valid
    rd_txn(0, 16'h0100, -1, 0, 32'h0);
    chk("timeout latency", last_rdv[0] - last_rden[0], 32'd8);
    chk("timeout data", last_rdata[0], 32'hDEAD_BEEF);
    chk("timeout count literal", 32'(cnt_o[0]), 32'd1);
    chk("timeout err literal", 32'(err_o[0]), 32'd1);
    rd_txn(0, 16'h4040, TMO + 2, 1, 32'h5555_AAAA);
    rd_txn(0, 16'h8020, 2, 1, 32'h7777_0000);
    chk("wrong-channel valid count", 32'(cnt_o[0]), 32'd3);

    // valid on the last RD_WAIT cycle and on the first
    rd_txn(0, 16'h4044, TMO - 1, 1, 32'hCAFE_0007);
    chk("last-cycle valid data", last_rdata[0], 32'hCAFE_0007);
    rd_txn(0, 16'h0008, 0, 0, 32'hBEEF_0000);
    chk("immediate valid latency", last_rdv[0] - last_rden[0], 32'd1);

    // stray valids while idle
    rd_valid_i[0] = 4'hF;
    tick();
    rd_valid_i[0] = 4'h0;
    tick();

    // unmapped channel on the 3-channel instance
    n = cyc;
    rd_txn(1, 16'hC000, 0, 3, 32'h0);
    chk("unmapped rd latency", last_rdv[1], n + 1);
    chk("unmapped rd data", last_rdata[1], 32'hDEAD_BEEF);
    chk("unmapped rd no strobe", last_rden[1], 32'hFFFF_FFFF);
    clr(1);
    cmd(1, 1'b0, 1'b1, 16'hC004, 32'h1111_1111);
    mm_write_i[1] = 1'b0;
    chk("unmapped wr err", 32'(err_o[1]), 32'd1);
    tick();
    rd_txn(1, 16'h8010, 1, 2, 32'h3333_2222);
    cmd(1, 1'b0, 1'b1, 16'h400C, 32'h4444_0000);
    mm_write_i[1] = 1'b0;
    tick();

    // simultaneous read and write
    clr(0);
    cmd(0, 1'b1, 1'b1, 16'h8030, 32'h5151_5151);
    mm_read_i[0] = 1'b0; mm_write_i[0] = 1'b0;
    chk("rw collision err", 32'(err_o[0]), 32'd1);
    chk("rw collision waitrequest", 32'(wait_o[0]), 32'd0);
    tick(); tick();

    // clear coinciding with a new error
    clr(1);
    stat_clr_i[1] = 1'b1;
    exp_err[1] = 1'b0; exp_cnt[1] = 0;
    cmd(1, 1'b0, 1'b1, 16'hC000, 32'h0);
    stat_clr_i[1] = 1'b0; mm_write_i[1] = 1'b0;
    chk("clr vs error", 32'(err_o[1]), 32'd1);
    tick();

    // reset in the middle of a read
    cmd(0, 1'b1, 1'b0, 16'h4010, 32'h0);
    mm_read_i[0] = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk_reset_vals(0);
    for (int i = 0; i < 2; i++) begin exp_cnt[i] = 0; exp_err[i] = 1'b0; end
    rd_valid_i[0] = 4'b0010;
    tick();
    rst = 1'b0;
    tick();
    rd_valid_i[0] = 4'h0;
    tick();
    rd_txn(0, 16'h4010, 2, 1, 32'h600D_0001);
    chk("post-reset read data", last_rdata[0], 32'h600D_0001);

    // statistics saturation and clear
    for (int t = 0; t < 300; t++) rd_txn(0, 16'h0000, -1, 0, 32'h0);
    chk("saturated count", 32'(cnt_o[0]), 32'd255);
    clr(0);
    tick();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
